alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched.sv | 164 ++++++++++++++++
 tb/tb_alu_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester round-robin scheduler driving an external multi-cycle ALU
// Commands pass IDLE -> LOAD -> EXEC -> RESP; an illegal op skips straight to RESP with an error.
module alu_sched #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [2:0] req0_op,
  input  logic [2:0] req1_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic [2:0] alu_in_sel,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_sel,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    EXEC = 2'b10,
    RESP = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [7:0] data_q, data_d;
  logic       id_q, id_d;
  logic       err_q, err_d;
  logic [2:0] cnt_q, cnt_d;
  logic       gnt_any;
  logic       gnt_id;
  logic [2:0] sel_op;

  // ptr_q names the requester that wins a tie; it flips to the loser after every grant.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = ptr_q;
    else                          gnt_id = ~req0_valid;
    sel_op = gnt_id ? req1_op : req0_op;
  end

  assign req0_ready = rst && (state_q == IDLE) && gnt_any && !gnt_id;
  assign req1_ready = rst && (state_q == IDLE) && gnt_any && gnt_id;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          op_d  = sel_op;
          a_d   = gnt_id ? req1_a : req0_a;
          b_d   = gnt_id ? req1_b : req0_b;
          id_d  = gnt_id;
          ptr_d = ~gnt_id;
          if (sel_op == 3'd7) begin
            err_d   = 1'b1;
            data_d  = 8'h00;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        cnt_d   = 3'(ALU_LAT - 1);
        state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          data_d  = alu_out;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      op_q    <= 3'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      data_q  <= 8'h00;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU controls follow rst directly so the reset command reaches the ALU without waiting on a flop.
  always_comb begin
    alu_in_sel  = 3'b100;
    alu_num1    = 8'h00;
    alu_num2    = 8'h00;
    alu_out_sel = 7'b0000000;
    if (!rst) begin
      alu_in_sel = 3'b001;
    end else begin
      case (state_q)
        LOAD: begin
          alu_in_sel  = 3'b010;
          alu_num1    = a_q;
          alu_num2    = b_q;
          alu_out_sel = 7'b1000000 >> op_q;
        end
        EXEC: begin
          alu_num1    = a_q;
          alu_num2    = b_q;
          alu_out_sel = 7'b1000000 >> op_q;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - scoreboard bench for alu_sched with a behavioural ALU behind each instance
// Two instances: default latency on the scoreboard, ALU_LAT=4 for the long-latency case.
module tb_alu_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       r0v, r1v, r0rdy, r1rdy, rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [2:0] r0op, r1op, in_sel;
  logic [7:0] r0a, r0b, r1a, r1b, num1, num2, alu_out, rsp_data;
  logic [6:0] out_sel;
  logic [1:0] st;

  logic       r0v4, r1v4, r0rdy4, r1rdy4, rsp_valid4, rsp_ready4, rsp_id4, rsp_err4;
  logic [2:0] r0op4, r1op4, in_sel4;
  logic [7:0] r0a4, r0b4, r1a4, r1b4, num14, num24, alu_out4, rsp_data4;
  logic [6:0] out_sel4;
  logic [1:0] st4;

  alu_sched u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req1_valid(r1v), .req0_ready(r0rdy), .req1_ready(r1rdy),
    .req0_op(r0op), .req1_op(r1op), .req0_a(r0a), .req0_b(r0b), .req1_a(r1a), .req1_b(r1b),
    .alu_in_sel(in_sel), .alu_num1(num1), .alu_num2(num2), .alu_out_sel(out_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .state(st)
  );

  alu_sched #(.ALU_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v4), .req1_valid(r1v4), .req0_ready(r0rdy4), .req1_ready(r1rdy4),
    .req0_op(r0op4), .req1_op(r1op4), .req0_a(r0a4), .req0_b(r0b4), .req1_a(r1a4), .req1_b(r1b4),
    .alu_in_sel(in_sel4), .alu_num1(num14), .alu_num2(num24), .alu_out_sel(out_sel4), .alu_out(alu_out4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_id(rsp_id4), .rsp_data(rsp_data4),
    .rsp_err(rsp_err4), .state(st4)
  );

  function automatic logic [7:0] alu_f(input logic [6:0] sel, input logic [7:0] x, input logic [7:0] y);
    case (sel)
      7'b1000000: return x + y;
      7'b0100000: return x - y;
      7'b0010000: return x & y;
      7'b0001000: return x | y;
      7'b0000100: return x ^ y;
      7'b0000010: return x << 1;
      7'b0000001: return ~(x & y);
      default:    return 8'h00;
    endcase
  endfunction

  logic [6:0] m_sel = '0, m_sel4 = '0;
  logic [7:0] m_a = '0, m_b = '0, m_a4 = '0, m_b4 = '0;
  always @(posedge clk) begin
    if (in_sel == 3'b010) begin m_sel <= out_sel; m_a <= num1; m_b <= num2; end
    if (in_sel4 == 3'b010) begin m_sel4 <= out_sel4; m_a4 <= num14; m_b4 <= num24; end
  end
  assign alu_out  = alu_f(m_sel, m_a, m_b);
  assign alu_out4 = alu_f(m_sel4, m_a4, m_b4);

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       err;
  } rsp_t;
  rsp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  rsp_t e;
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=%0h err=%0d expected no response", rsp_id, rsp_data, rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
    if (r0v && r1v) check("ready_exclusive", 32'(r0rdy & r1rdy), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output logic got, output logic ok);
    ok  = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (r0rdy || r1rdy) begin
        ok  = 1'b1;
        got = r1rdy;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no ready expected a grant within 20 cycles");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic got, ok;
    rst = 1'b0;
    r0v = 1'b1; r1v = 1'b0; r0op = 3'd0; r1op = 3'd0;
    r0a = 8'h00; r0b = 8'h00; r1a = 8'h00; r1b = 8'h00; rsp_ready = 1'b1;
    r0v4 = 1'b0; r1v4 = 1'b0; r0op4 = 3'd0; r1op4 = 3'd0;
    r0a4 = 8'h00; r0b4 = 8'h00; r1a4 = 8'h00; r1b4 = 8'h00; rsp_ready4 = 1'b1;
    #2;
    check("rst_state", 32'(st), 32'd0);
    check("rst_in_sel", 32'(in_sel), 32'b001);
    check("rst_ready0", 32'(r0rdy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_nums", {16'd0, num1, num2}, 32'd0);
    check("rst_in_sel4", 32'(in_sel4), 32'b001);
    r0v = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // Single add from req0, default latency
    r0op = 3'd0; r0a = 8'h57; r0b = 8'h1A; r0v = 1'b1;
    exp_q.push_back('{id: 1'b0, data: 8'h71, err: 1'b0});
    #1;
    check("add_ready0", 32'(r0rdy), 32'd1);
    check("add_ready1", 32'(r1rdy), 32'd0);
    tick();
    r0v = 1'b0;
    check("add_load_state", 32'(st), 32'd1);
    check("add_load_in_sel", 32'(in_sel), 32'b010);
    check("add_load_num1", 32'(num1), 32'h57);
    check("add_load_num2", 32'(num2), 32'h1A);
    check("add_load_out_sel", 32'(out_sel), 32'b1000000);
    tick();
    check("add_exec_state", 32'(st), 32'd2);
    check("add_exec_in_sel", 32'(in_sel), 32'b100);
    check("add_exec_num1", 32'(num1), 32'h57);
    tick();
    check("add_resp_state", 32'(st), 32'd3);
    check("add_resp_valid", 32'(rsp_valid), 32'd1);
    tick();
    check("add_idle_state", 32'(st), 32'd0);

    // Illegal op from req1 skips LOAD
    r1op = 3'd7; r1a = 8'h12; r1b = 8'h34; r1v = 1'b1;
    exp_q.push_back('{id: 1'b1, data: 8'h00, err: 1'b1});
    tick();
    r1v = 1'b0;
    check("ill_state", 32'(st), 32'd3);
    check("ill_rsp", {29'd0, rsp_valid, rsp_err, rsp_id}, 32'b111);
    check("ill_data", 32'(rsp_data), 32'h00);
    tick();
    check("ill_idle_state", 32'(st), 32'd0);

    // Back-pressure on the response with req1 waiting
    r0op = 3'd3; r0a = 8'hF0; r0b = 8'h0F; r0v = 1'b1; rsp_ready = 1'b0;
    exp_q.push_back('{id: 1'b0, data: 8'hFF, err: 1'b0});
    tick();
    r0v = 1'b0;
    r1op = 3'd5; r1v = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_state", 32'(st), 32'd3);
      check("bp_rsp", {22'd0, rsp_valid, rsp_id, rsp_err, rsp_data}, {22'd0, 1'b1, 1'b0, 1'b0, 8'hFF});
      check("bp_ready", {30'd0, r0rdy, r1rdy}, 32'd0);
      if (i < 2) tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_state", 32'(st), 32'd0);
    #1;
    check("bp_idle_ready1", 32'(r1rdy), 32'd1);
    r1v = 1'b0;
    #1;
    check("drop_ready1", 32'(r1rdy), 32'd0);
    tick();
    check("drop_no_grant", 32'(st), 32'd0);

    // Round-robin after a fresh reset
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    r0op = 3'd2; r0a = 8'hCC; r0b = 8'hAA;
    r1op = 3'd4; r1a = 8'hCC; r1b = 8'hAA;
    r0v = 1'b1; r1v = 1'b1;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(k[0] ? '{id: 1'b1, data: 8'h66, err: 1'b0} : '{id: 1'b0, data: 8'h88, err: 1'b0});
    for (int k = 0; k < 4; k++) begin
      wait_ready(got, ok);
      if (ok) check("rr_grant", 32'(got), 32'(k[0]));
      tick();
    end
    r0v = 1'b0; r1v = 1'b0;
    wait_drain();

    // Reset in the middle of EXEC discards the command
    r0op = 3'd1; r0a = 8'h10; r0b = 8'h01; r0v = 1'b1;
    wait_ready(got, ok);
    tick();
    check("mid_load_state", 32'(st), 32'd1);
    tick();
    check("mid_exec_state", 32'(st), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_state", 32'(st), 32'd0);
    check("mid_rst_in_sel", 32'(in_sel), 32'b001);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready0", 32'(r0rdy), 32'd0);
    #2 rst = 1'b1;
    exp_q.push_back('{id: 1'b0, data: 8'h0F, err: 1'b0});
    wait_ready(got, ok);
    if (ok) check("mid_reaccept_id", 32'(got), 32'd0);
    tick();
    r0v = 1'b0;
    wait_drain();

    // Long-latency instance
    r0op4 = 3'd6; r0a4 = 8'h3C; r0b4 = 8'h5A; r0v4 = 1'b1;
    #1;
    check("lat4_ready0", 32'(r0rdy4), 32'd1);
    tick();
    r0v4 = 1'b0;
    check("lat4_load_state", 32'(st4), 32'd1);
    check("lat4_load_in_sel", 32'(in_sel4), 32'b010);
    check("lat4_out_sel", 32'(out_sel4), 32'b0000001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lat4_exec_state", 32'(st4), 32'd2);
      check("lat4_exec_in_sel", 32'(in_sel4), 32'b100);
      check("lat4_exec_out_sel", 32'(out_sel4), 32'b0000001);
    end
    tick();
    check("lat4_resp_state", 32'(st4), 32'd3);
    check("lat4_rsp", {22'd0, rsp_valid4, rsp_id4, rsp_err4, rsp_data4}, {22'd0, 1'b1, 1'b0, 1'b0, 8'hE7});
    tick();
    check("lat4_idle_state", 32'(st4), 32'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
